// File: rtl/rs485_tx_arbiter.sv
// Frame-level round-robin arbiter and byte sequencer in front of a 16x-oversampled
// RS485 transmitter. One requester owns the transmitter per frame, followed by a quiet gap.
module rs485_tx_arbiter #(
  parameter int GAP_CYC  = 32,
  parameter int START_TO = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_datain,
  output logic       tx_wrsig,
  input  logic       tx_idle,
  output logic [1:0] grant,
  output logic       frame_done,
  output logic       err
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);
  localparam logic [7:0] TO_LAST  = 8'(START_TO - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, BUSY, GAP} state_t;

  state_t     state;
  logic       rr_last;
  logic       owner;
  logic       last_flag;
  logic       retry;
  logic [1:0] pause_cnt;
  logic [7:0] to_cnt;
  logic [7:0] gap_cnt;

  logic       winner;
  logic       own_valid;
  logic [7:0] own_data;
  logic       own_last;

  // With both requesting, whoever did not win last time goes next.
  assign winner    = (req0_valid && req1_valid) ? ~rr_last : req1_valid;
  assign own_valid = owner ? req1_valid : req0_valid;
  assign own_data  = owner ? req1_data  : req0_data;
  assign own_last  = owner ? req1_last  : req0_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      owner      <= 1'b0;
      last_flag  <= 1'b0;
      retry      <= 1'b0;
      pause_cnt  <= 2'd0;
      to_cnt     <= 8'd0;
      gap_cnt    <= 8'd0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      tx_datain  <= 8'd0;
      tx_wrsig   <= 1'b0;
      grant      <= 2'b00;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          // A busy transmitter may still be finishing a frame started before reset.
          if (!tx_idle && (req0_valid || req1_valid)) begin
            owner   <= winner;
            rr_last <= winner;
            grant   <= winner ? 2'b10 : 2'b01;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (own_valid) begin
            req0_ready <= ~owner;
            req1_ready <= owner;
            tx_datain  <= own_data;
            last_flag  <= own_last;
            tx_wrsig   <= 1'b1;
            to_cnt     <= 8'd0;
            retry      <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          // After a timeout, wrsig stays low two cycles so the retry is a clean rising edge.
          if (retry) begin
            if (pause_cnt == 2'd0) begin
              tx_wrsig <= 1'b1;
              to_cnt   <= 8'd0;
              retry    <= 1'b0;
            end else begin
              pause_cnt <= pause_cnt - 2'd1;
            end
          end else if (tx_idle) begin
            tx_wrsig <= 1'b0;
            state    <= BUSY;
          end else if (to_cnt == TO_LAST) begin
            err       <= 1'b1;
            tx_wrsig  <= 1'b0;
            retry     <= 1'b1;
            pause_cnt <= 2'd1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        BUSY: begin
          if (!tx_idle) begin
            if (last_flag) begin
              frame_done <= 1'b1;
              grant      <= 2'b00;
              gap_cnt    <= 8'd0;
              state      <= GAP;
            end else begin
              state <= LOAD;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs485_tx_arbiter.sv
// Bench for rs485_tx_arbiter: behavioural transmitter, byte-stream requesters and
// a frame-level reference model compared against the DUT every cycle.
module tb_rs485_tx_arbiter;

  localparam int GAP_CYC  = 32;
  localparam int START_TO = 16;
  localparam int TX_RESP  = 3;
  localparam int TX_BYTE  = 168;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic [7:0] tx_datain;
  logic       tx_wrsig;
  logic       tx_idle;
  logic [1:0] grant;
  logic       frame_done;
  logic       err;

  rs485_tx_arbiter #(.GAP_CYC(GAP_CYC), .START_TO(START_TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_datain(tx_datain), .tx_wrsig(tx_wrsig), .tx_idle(tx_idle),
    .grant(grant), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // requester byte streams ({last, data}) and the per-requester expected wire order
  logic [8:0] q0[$], q1[$], e0[$], e1[$];
  logic       stall0, stall1;

  // transmitter model
  int   ignore_edges, resp_cnt, busy_cnt, wr_rises;
  logic tx_busy, tx_hold, tx_prev_wr;

  // reference model state
  int         rr_model, owner, pending_last, frames_seen, err_seen;
  int         rdy_cnt0, rdy_cnt1;
  int         hi_run, last_hi, fell, watch, lo_cnt;
  int         gap_track, gap_cnt, gap_pend, cap_valid;
  logic [7:0] cap_byte, err_data;
  logic [1:0] prev_grant;
  logic       prev_wrsig;
  logic [7:0] byte_log[$];
  logic [1:0] grant_log[$];
  logic [7:0] t2_exp[8];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic addByte(input int n, input logic [7:0] d, input logic l);
    if (n == 0) begin q0.push_back({l, d}); e0.push_back({l, d}); end
    else begin q1.push_back({l, d}); e1.push_back({l, d}); end
  endtask

  task automatic addFrame(input int n, input int len);
    for (int i = 0; i < len; i++) addByte(n, 8'($urandom), (i == len - 1));
  endtask

  task automatic captureByte();
    logic [8:0] hd;
    byte_log.push_back(tx_datain);
    cap_valid = 1;
    cap_byte  = tx_datain;
    if (owner == 0 && e0.size() > 0) hd = e0.pop_front();
    else if (owner == 1 && e1.size() > 0) hd = e1.pop_front();
    else begin
      check("tx_byte_has_owner", 0, 1);
      return;
    end
    check("tx_byte_order", int'(tx_datain), int'(hd[7:0]));
    pending_last = int'(hd[8]);
  endtask

  task automatic checkOutput();
    int w;
    if (rst) begin
      check("reset_outputs", int'({tx_datain, tx_wrsig, grant, req0_ready, req1_ready, frame_done, err}), 0);
      rr_model = 1; owner = -1; pending_last = 0; hi_run = 0; last_hi = 0; fell = 0; watch = 0;
      gap_track = 0; cap_valid = 0; prev_grant = 2'b00; prev_wrsig = 1'b0;
      return;
    end
    check("grant_onehot", int'($countones(grant) <= 1), 1);
    if (tx_wrsig) check("wrsig_has_owner", int'(grant != 2'b00), 1);
    if (req0_ready) begin
      rdy_cnt0++;
      check("ready0_granted", int'(grant[0]), 1);
      check("ready0_valid", int'(req0_valid), 1);
      if (q0.size() > 0) check("ready0_datain", int'(tx_datain), int'(q0[0][7:0]));
    end
    if (req1_ready) begin
      rdy_cnt1++;
      check("ready1_granted", int'(grant[1]), 1);
      check("ready1_valid", int'(req1_valid), 1);
      if (q1.size() > 0) check("ready1_datain", int'(tx_datain), int'(q1[0][7:0]));
    end
    if (prev_grant == 2'b00 && grant != 2'b00) begin
      check("arb_tx_free", int'(tx_idle), 0);
      check("arb_prev_frame_closed", pending_last, 0);
      if (req0_valid && req1_valid) w = (rr_model == 1) ? 0 : 1;
      else if (req0_valid) w = 0;
      else if (req1_valid) w = 1;
      else w = -1;
      check("arb_winner", int'(grant), (w < 0) ? 0 : (1 << w));
      if (w >= 0) rr_model = w;
      owner = w;
      grant_log.push_back(grant);
      // quiet cycles after frame_done, plus the idle cycle that registers the grant
      if (gap_track != 0 && gap_pend != 0) check("gap_length", gap_cnt, GAP_CYC + 1);
      gap_track = 0;
    end else if (prev_grant != 2'b00 && grant != 2'b00) begin
      check("grant_stable", int'(grant), int'(prev_grant));
    end
    if (prev_grant != 2'b00 && grant == 2'b00) check("grant_clear_with_done", int'(frame_done), 1);
    if (frame_done) begin
      check("done_after_last_byte", pending_last, 1);
      check("done_clears_grant", int'(grant), 0);
      check("done_tx_free", int'(tx_idle), 0);
      frames_seen++;
      pending_last = 0; owner = -1;
      gap_track = 1; gap_cnt = 1; gap_pend = int'(req0_valid || req1_valid);
    end else if (gap_track != 0 && grant == 2'b00) begin
      gap_cnt++;
      if (!(req0_valid || req1_valid)) gap_pend = 0;
    end
    fell = 0;
    if (tx_wrsig) hi_run++;
    else begin
      if (prev_wrsig) begin last_hi = hi_run; fell = 1; end
      hi_run = 0;
    end
    if (err) begin
      err_seen++;
      check("err_after_timeout", (fell != 0) ? last_hi : 0, START_TO);
      watch = 1; lo_cnt = 1; err_data = tx_datain;
    end else if (watch != 0) begin
      if (!tx_wrsig) lo_cnt++;
      else begin
        check("retry_low_cycles", lo_cnt, 2);
        check("retry_same_byte", int'(tx_datain), int'(err_data));
        watch = 0;
      end
    end
    if (cap_valid != 0 && tx_busy) check("datain_stable", int'(tx_datain), int'(cap_byte));
    prev_grant = grant;
    prev_wrsig = tx_wrsig;
  endtask

  task automatic applyStimulus();
    if (tx_wrsig && !tx_prev_wr) begin
      wr_rises++;
      if (ignore_edges > 0) ignore_edges--;
      else if (!tx_busy && resp_cnt == 0) resp_cnt = TX_RESP;
    end
    tx_prev_wr = tx_wrsig;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        tx_busy = 1'b1; busy_cnt = TX_BYTE;
        captureByte();
      end
    end else if (tx_busy) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
    tx_idle = tx_busy || tx_hold;
    if (req0_ready && q0.size() > 0) void'(q0.pop_front());
    if (req1_ready && q1.size() > 0) void'(q1.pop_front());
    req0_valid = (q0.size() > 0) && !stall0;
    req0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'd0;
    req0_last  = (q0.size() > 0) ? q0[0][8] : 1'b0;
    req1_valid = (q1.size() > 0) && !stall1;
    req1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'd0;
    req1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    applyStimulus();
  endtask

  task automatic runUntilFrames(input int target, input int budget, input string name);
    int n = 0;
    while (frames_seen < target && n < budget) begin stepCycle(); n++; end
    check({name, "_frames_in_time"}, int'(frames_seen >= target), 1);
  endtask

  task automatic runUntilBusy(input logic level, input int budget, input string name);
    int n = 0;
    while (tx_busy != level && n < budget) begin stepCycle(); n++; end
    check({name, "_tx_busy_level"}, int'(tx_busy), int'(level));
  endtask

  initial begin
    int base0, base1, basef, base_err, base_wr, n;
    clk = 1'b0; rst = 1'b1;
    req0_valid = 0; req0_data = 0; req0_last = 0;
    req1_valid = 0; req1_data = 0; req1_last = 0;
    stall0 = 0; stall1 = 0; tx_idle = 0; tx_busy = 0; tx_hold = 0; tx_prev_wr = 0;
    ignore_edges = 0; resp_cnt = 0; busy_cnt = 0; wr_rises = 0;
    rr_model = 1; owner = -1; pending_last = 0; frames_seen = 0; err_seen = 0;
    rdy_cnt0 = 0; rdy_cnt1 = 0; hi_run = 0; last_hi = 0; fell = 0; watch = 0; lo_cnt = 0;
    gap_track = 0; gap_cnt = 0; gap_pend = 0; cap_valid = 0; cap_byte = 0; err_data = 0;
    prev_grant = 2'b00; prev_wrsig = 1'b0;
    t2_exp = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
    repeat (3) stepCycle();
    rst = 1'b0;

    $display("[TB] single two-byte frame from req0");
    byte_log.delete(); grant_log.delete(); base0 = rdy_cnt0; base_wr = wr_rises;
    addByte(0, 8'hA5, 1'b0); addByte(0, 8'h3C, 1'b1);
    runUntilFrames(1, 2000, "single");
    check("single_byte_count", byte_log.size(), 2);
    check("single_byte0", int'(byte_log[0]), 'hA5);
    check("single_byte1", int'(byte_log[1]), 'h3C);
    check("single_ready_pulses", rdy_cnt0 - base0, 2);
    check("single_wrsig_edges", wr_rises - base_wr, 2);
    check("single_grant", int'(grant_log[0]), 1);
    repeat (40) stepCycle();
    check("single_no_rearb", grant_log.size(), 1);

    $display("[TB] contention from reset");
    @(posedge clk); #1 rst = 1'b1;
    stepCycle();
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    addByte(0, 8'h10, 1'b0); addByte(0, 8'h11, 1'b1); addByte(0, 8'h12, 1'b0); addByte(0, 8'h13, 1'b1);
    addByte(1, 8'h20, 1'b0); addByte(1, 8'h21, 1'b1); addByte(1, 8'h22, 1'b0); addByte(1, 8'h23, 1'b1);
    stepCycle();
    rst = 1'b0;
    byte_log.delete(); grant_log.delete();
    runUntilFrames(frames_seen + 4, 6000, "contend");
    check("contend_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) check("contend_grant_order", int'(grant_log[i]), (i % 2 == 0) ? 1 : 2);
    check("contend_byte_count", byte_log.size(), 8);
    for (int i = 0; i < 8; i++) check("contend_byte_order", int'(byte_log[i]), int'(t2_exp[i]));

    $display("[TB] owner stall");
    grant_log.delete(); base0 = rdy_cnt0; base1 = rdy_cnt1; basef = frames_seen;
    addByte(1, 8'h31, 1'b0); addByte(1, 8'h32, 1'b0); addByte(1, 8'h33, 1'b1);
    n = 0;
    while (rdy_cnt1 == base1 && n < 500) begin stepCycle(); n++; end
    check("stall_first_accept", rdy_cnt1 - base1, 1);
    stall1 = 1'b1;
    addByte(0, 8'h40, 1'b0); addByte(0, 8'h41, 1'b1);
    runUntilBusy(1'b1, 100, "stall_start");
    runUntilBusy(1'b0, 400, "stall_end");
    repeat (50) stepCycle();
    check("stall_grant_held", int'(grant), 2);
    check("stall_no_ready0", rdy_cnt0 - base0, 0);
    check("stall_no_ready1", rdy_cnt1 - base1, 1);
    stall1 = 1'b0;
    runUntilFrames(basef + 2, 4000, "stall");
    check("stall_grant_count", grant_log.size(), 2);
    check("stall_grant_first", int'(grant_log[0]), 2);
    check("stall_grant_second", int'(grant_log[1]), 1);

    $display("[TB] start timeout and retry");
    byte_log.delete(); base_err = err_seen; base_wr = wr_rises;
    ignore_edges = 1;
    addByte(0, 8'h5A, 1'b1);
    runUntilFrames(frames_seen + 1, 1000, "timeout");
    check("timeout_err_pulses", err_seen - base_err, 1);
    check("timeout_wrsig_edges", wr_rises - base_wr, 2);
    check("timeout_byte", int'(byte_log[0]), 'h5A);

    $display("[TB] reset mid-frame");
    grant_log.delete();
    addByte(1, 8'h66, 1'b0); addByte(1, 8'h67, 1'b1);
    runUntilBusy(1'b1, 200, "midreset_start");
    tx_hold = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    repeat (2) stepCycle();
    rst = 1'b0;
    grant_log.delete();
    addByte(0, 8'h70, 1'b1); addByte(1, 8'h71, 1'b1);
    repeat (40) stepCycle();
    check("midreset_no_grant", int'(grant), 0);
    tx_hold = 1'b0;
    runUntilFrames(frames_seen + 2, 2000, "midreset");
    check("midreset_grant_count", grant_log.size(), 2);
    check("midreset_first_req0", int'(grant_log[0]), 1);
    check("midreset_second_req1", int'(grant_log[1]), 2);

    $display("[TB] single-byte frame");
    byte_log.delete(); grant_log.delete(); base_wr = wr_rises;
    addByte(1, 8'hFF, 1'b1);
    runUntilFrames(frames_seen + 1, 600, "onebyte");
    check("onebyte_value", int'(byte_log[0]), 'hFF);
    check("onebyte_grant", int'(grant_log[0]), 2);
    check("onebyte_wrsig_edges", wr_rises - base_wr, 1);
    check("onebyte_grant_after", int'(grant), 0);

    $display("[TB] randomized frames");
    basef = frames_seen;
    for (int i = 0; i < 8; i++) addFrame(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
    ignore_edges = int'($urandom_range(0, 1));
    n = 0;
    while (frames_seen < basef + 8 && n < 20000) begin
      if ($urandom_range(0, 63) == 0) stall0 = ~stall0;
      if ($urandom_range(0, 63) == 0) stall1 = ~stall1;
      stepCycle();
      n++;
    end
    stall0 = 1'b0; stall1 = 1'b0;
    runUntilFrames(basef + 8, 8000, "random");
    check("random_drained", e0.size() + e1.size() + q0.size() + q1.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
